issue_hazard_unit: RTL and testbench

ISSUE_HAZARD_UNIT -- requirements
Module: issue_hazard_unit

---
 rtl/issue_hazard_unit.sv | 141 ++++++++++++++
 tb/tb_issue_hazard_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_hazard_unit.sv
// Issue-stage hazard unit: inserts load-use, control and memory-wait bubbles
// in front of the control unit and holds fetch while the held instruction waits.
module issue_hazard_unit #(
   parameter int LOAD_BUBBLES   = 2,
   parameter int BRANCH_BUBBLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] instr_in,
   input  logic        mem_busy,
   input  logic        flush,
   output logic        fetch_hold,
   output logic        out_valid,
   output logic [1:0]  instruction_type,
   output logic [4:0]  opcode,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        bubble_active
);

   typedef enum logic [1:0] {ISSUE, LOAD_STALL, BRANCH_STALL, MEM_STALL} state_t;

   typedef struct packed {
      logic       valid;
      logic       bubble;
      logic [1:0] ty;
      logic [4:0] op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } out_t;

   localparam logic [1:0] TY_MEM      = 2'b00;
   localparam logic [1:0] TY_STALL    = 2'b01;
   localparam logic [1:0] TY_CTRL     = 2'b10;
   localparam logic [4:0] OP_STALL    = 5'b00101;
   localparam logic [4:0] OP_STALL_RD = 5'b00110;
   localparam logic [4:0] OP_STALL_WR = 5'b00111;
   localparam logic [2:0] LOAD_INIT   = 3'(LOAD_BUBBLES - 1);
   localparam logic [2:0] BRANCH_INIT = 3'(BRANCH_BUBBLES);

   state_t     state;
   out_t       out_q;
   logic [2:0] stall_cnt;
   logic [4:0] load_rd;
   logic       load_pend;

   logic [1:0] in_type;
   logic [4:0] in_op, in_rd, in_rs1, in_rs2;
   logic [9:0] unused_low;
   assign {in_type, in_op, in_rd, in_rs1, in_rs2} = instr_in[31:10];
   assign unused_low = instr_in[9:0];

   logic is_load, is_store, rs1_only, src_hit, eff_pend, issuing, mem_wait, hazard;
   assign is_load  = (in_type == TY_MEM) && !in_op[3];
   assign is_store = (in_type == TY_MEM) &&  in_op[3];
   assign rs1_only = in_type[0] && in_op[4];
   assign src_hit  = (in_rs1 == load_rd) ||
                     (is_store ? (in_rd == load_rd) : (!rs1_only && (in_rs2 == load_rd)));

   // Resuming from a load or memory stall re-runs issue with the load dependency already satisfied.
   assign eff_pend = load_pend && (state == ISSUE);
   assign issuing  = (state == ISSUE) || (state == MEM_STALL) ||
                     ((state == LOAD_STALL) && (stall_cnt == 3'd0));
   assign mem_wait = instr_valid && (in_type == TY_MEM) && mem_busy;
   assign hazard   = instr_valid && eff_pend && src_hit;

   // NOTE: default assignment first so no path through always_comb infers a latch.
   always_comb begin
      fetch_hold = 1'b0;
      if (rst && !flush)
         fetch_hold = issuing ? (mem_wait || hazard) : 1'b1;
   end

   function automatic out_t make_bubble(input logic [4:0] op);
      out_t b;
      b        = '0;
      b.valid  = 1'b1;
      b.bubble = 1'b1;
      b.ty     = TY_STALL;
      b.op     = op;
      return b;
   endfunction

   // NOTE: every register below uses non-blocking assignment so all state updates see pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ISSUE;
         out_q     <= '0;
         stall_cnt <= '0;
         load_rd   <= '0;
         load_pend <= 1'b0;
      end else if (flush) begin
         state     <= ISSUE;
         out_q     <= '0;
         stall_cnt <= '0;
         load_pend <= 1'b0;
      end else if (issuing) begin
         if (!instr_valid) begin
            state     <= ISSUE;
            out_q     <= '0;
            load_pend <= 1'b0;
         end else if (mem_wait) begin
            state <= MEM_STALL;
            out_q <= make_bubble(in_op[3] ? OP_STALL_WR : OP_STALL_RD);
         end else if (hazard) begin
            state     <= LOAD_STALL;
            out_q     <= make_bubble(OP_STALL);
            stall_cnt <= LOAD_INIT;
         end else begin
            out_q     <= {1'b1, 1'b0, instr_in[31:10]};
            load_pend <= is_load;
            if (is_load)
               load_rd <= in_rd;
            if ((in_type == TY_CTRL) && (BRANCH_BUBBLES > 0)) begin
               state     <= BRANCH_STALL;
               stall_cnt <= BRANCH_INIT;
            end else begin
               state <= ISSUE;
            end
         end
      end else begin
         out_q <= make_bubble(OP_STALL);
         if (stall_cnt != 3'd0)
            stall_cnt <= stall_cnt - 3'd1;
         if ((state == BRANCH_STALL) && (stall_cnt <= 3'd1))
            state <= ISSUE;
      end
   end

   assign out_valid        = out_q.valid;
   assign bubble_active    = out_q.bubble;
   assign instruction_type = out_q.ty;
   assign opcode           = out_q.op;
   assign rd               = out_q.rd;
   assign rs1              = out_q.rs1;
   assign rs2              = out_q.rs2;

endmodule

// File: tb/tb_issue_hazard_unit.sv
// Bench for issue_hazard_unit: directed vector table, async-reset sequences,
// then random traffic checked against a bubble-queue reference model.
module tb_issue_hazard_unit;

   localparam int LB = 2;
   localparam int BB = 2;
   localparam logic [4:0] STD = 5'b00101;
   localparam logic [4:0] SRD = 5'b00110;
   localparam logic [4:0] SWR = 5'b00111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic [31:0] instr_in = '0;
   logic        mem_busy = 1'b0;
   logic        flush = 1'b0;
   logic        fetch_hold, out_valid, bubble_active;
   logic [1:0]  instruction_type;
   logic [4:0]  opcode, rd, rs1, rs2;

   int errors = 0;
   int checks = 0;

   issue_hazard_unit #(.LOAD_BUBBLES(LB), .BRANCH_BUBBLES(BB)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_in(instr_in),
      .mem_busy(mem_busy), .flush(flush), .fetch_hold(fetch_hold),
      .out_valid(out_valid), .instruction_type(instruction_type), .opcode(opcode),
      .rd(rd), .rs1(rs1), .rs2(rs2), .bubble_active(bubble_active)
   );

   always #5 clk = ~clk;

   logic [23:0] out_pk;
   assign out_pk = {out_valid, bubble_active, instruction_type, opcode, rd, rs1, rs2};

   function automatic logic [31:0] mk(input logic [1:0] t, input logic [4:0] o,
                                      input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
      return {t, o, d, a, b, 10'd0};
   endfunction

   function automatic logic [23:0] exp_pass(input logic [31:0] i);
      return {2'b10, i[31:10]};
   endfunction

   function automatic logic [23:0] exp_stall(input logic [4:0] o);
      return {2'b11, 2'b01, o, 15'd0};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // One clock: drive at the falling edge, check fetch_hold before the rising edge, outputs after it.
   task automatic cycle(input logic v, input logic [31:0] ins, input logic b, input logic f,
                        input logic eh, input logic [23:0] eo, input string tag);
      instr_valid = v;
      instr_in    = ins;
      mem_busy    = b;
      flush       = f;
      #1;
      check({tag, " fetch_hold"}, 32'(fetch_hold), 32'(eh));
      @(posedge clk);
      #1;
      check({tag, " outputs"}, 32'(out_pk), 32'(eo));
      @(negedge clk);
   endtask

   // Reference model: a queue of bubbles still owed, plus the pending-load register.
   logic [4:0] m_q[$];
   bit         m_pend;
   logic [4:0] m_lrd;

   function automatic bit reads_reg(input logic [31:0] i, input logic [4:0] r);
      logic [1:0] t;
      logic [4:0] op;
      logic [4:0] srcs[$];
      t  = i[31:30];
      op = i[29:25];
      srcs.push_back(i[19:15]);
      if (t == 2'b00 && (op[4:3] == 2'b01 || op[4:3] == 2'b11))
         srcs.push_back(i[24:20]);
      else if (!((t == 2'b01 || t == 2'b11) && op[4]))
         srcs.push_back(i[14:10]);
      foreach (srcs[k])
         if (srcs[k] == r) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model(input logic v, input logic [31:0] ins, input logic b, input logic f,
                        output logic eh, output logic [23:0] eo);
      logic [1:0] t;
      logic [4:0] op;
      t  = ins[31:30];
      op = ins[29:25];
      if (f) begin
         eh = 1'b0; eo = '0; m_q.delete(); m_pend = 1'b0;
      end else if (m_q.size() > 0) begin
         eh = 1'b1; eo = exp_stall(m_q.pop_front());
      end else if (!v) begin
         eh = 1'b0; eo = '0; m_pend = 1'b0;
      end else if (t == 2'b00 && b) begin
         eh = 1'b1; eo = exp_stall((op[4:3] == 2'b01 || op[4:3] == 2'b11) ? SWR : SRD);
         m_pend = 1'b0;
      end else if (m_pend && reads_reg(ins, m_lrd)) begin
         eh = 1'b1; eo = exp_stall(STD);
         for (int k = 1; k < LB; k++) m_q.push_back(STD);
         m_pend = 1'b0;
      end else begin
         eh = 1'b0; eo = exp_pass(ins);
         m_pend = (t == 2'b00) && (op[4:3] == 2'b00 || op[4:3] == 2'b10);
         if (m_pend) m_lrd = ins[24:20];
         if (t == 2'b10)
            for (int k = 0; k < BB; k++) m_q.push_back(STD);
      end
   endtask

   typedef struct packed {
      logic        v;
      logic [31:0] ins;
      logic        b;
      logic        f;
      logic        eh;
      logic [23:0] eo;
   } vec_t;

   vec_t vecs[$];

   logic [31:0] ld3, add3, imm, br, add2, st, str3, sys1, sys2, cur;
   logic        cur_v, rb, rf, prev_hold, eh;
   logic [23:0] eo;

   initial begin
      ld3  = mk(2'b00, 5'b00000, 5'd3, 5'd1, 5'd0);
      add3 = mk(2'b01, 5'b00001, 5'd5, 5'd3, 5'd2);
      imm  = mk(2'b01, 5'b10001, 5'd6, 5'd4, 5'd3);
      br   = mk(2'b10, 5'b00010, 5'd0, 5'd7, 5'd8);
      add2 = mk(2'b01, 5'b00011, 5'd1, 5'd2, 5'd3);
      st   = mk(2'b00, 5'b01000, 5'd9, 5'd10, 5'd0);
      str3 = mk(2'b00, 5'b11000, 5'd3, 5'd1, 5'd0);
      sys1 = mk(2'b11, 5'b10000, 5'd1, 5'd2, 5'd3);
      sys2 = mk(2'b11, 5'b00100, 5'd1, 5'd2, 5'd3);

      // load-use on rs1: load, two bubbles, then the add
      vecs.push_back('{1'b1, ld3,  1'b0, 1'b0, 1'b0, exp_pass(ld3)});
      vecs.push_back('{1'b1, add3, 1'b0, 1'b0, 1'b1, exp_stall(STD)});
      vecs.push_back('{1'b1, add3, 1'b0, 1'b0, 1'b1, exp_stall(STD)});
      vecs.push_back('{1'b1, add3, 1'b0, 1'b0, 1'b0, exp_pass(add3)});
      // immediate op reads rs1 only: no bubble
      vecs.push_back('{1'b1, ld3,  1'b0, 1'b0, 1'b0, exp_pass(ld3)});
      vecs.push_back('{1'b1, imm,  1'b0, 1'b0, 1'b0, exp_pass(imm)});
      // control instruction: two bubbles after it
      vecs.push_back('{1'b1, br,   1'b0, 1'b0, 1'b0, exp_pass(br)});
      vecs.push_back('{1'b1, add2, 1'b0, 1'b0, 1'b1, exp_stall(STD)});
      vecs.push_back('{1'b1, add2, 1'b0, 1'b0, 1'b1, exp_stall(STD)});
      vecs.push_back('{1'b1, add2, 1'b0, 1'b0, 1'b0, exp_pass(add2)});
      // store with memory busy three cycles
      vecs.push_back('{1'b1, st,   1'b1, 1'b0, 1'b1, exp_stall(SWR)});
      vecs.push_back('{1'b1, st,   1'b1, 1'b0, 1'b1, exp_stall(SWR)});
      vecs.push_back('{1'b1, st,   1'b1, 1'b0, 1'b1, exp_stall(SWR)});
      vecs.push_back('{1'b1, st,   1'b0, 1'b0, 1'b0, exp_pass(st)});
      // load with memory busy one cycle
      vecs.push_back('{1'b1, ld3,  1'b1, 1'b0, 1'b1, exp_stall(SRD)});
      vecs.push_back('{1'b1, ld3,  1'b0, 1'b0, 1'b0, exp_pass(ld3)});
      // flush while the second load bubble is on the outputs
      vecs.push_back('{1'b1, add3, 1'b0, 1'b0, 1'b1, exp_stall(STD)});
      vecs.push_back('{1'b1, add3, 1'b0, 1'b0, 1'b1, exp_stall(STD)});
      vecs.push_back('{1'b1, add3, 1'b0, 1'b1, 1'b0, 24'd0});
      vecs.push_back('{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 24'd0});
      vecs.push_back('{1'b1, add3, 1'b0, 1'b0, 1'b0, exp_pass(add3)});
      // store compares its rd
      vecs.push_back('{1'b1, ld3,  1'b0, 1'b0, 1'b0, exp_pass(ld3)});
      vecs.push_back('{1'b1, str3, 1'b0, 1'b0, 1'b1, exp_stall(STD)});
      vecs.push_back('{1'b1, str3, 1'b0, 1'b0, 1'b1, exp_stall(STD)});
      vecs.push_back('{1'b1, str3, 1'b0, 1'b0, 1'b0, exp_pass(str3)});
      // type 11 with opcode[4]=1 ignores rs2; with opcode[4]=0 it compares rs2
      vecs.push_back('{1'b1, ld3,  1'b0, 1'b0, 1'b0, exp_pass(ld3)});
      vecs.push_back('{1'b1, sys1, 1'b0, 1'b0, 1'b0, exp_pass(sys1)});
      vecs.push_back('{1'b1, ld3,  1'b0, 1'b0, 1'b0, exp_pass(ld3)});
      vecs.push_back('{1'b1, sys2, 1'b0, 1'b0, 1'b1, exp_stall(STD)});
      vecs.push_back('{1'b1, sys2, 1'b0, 1'b0, 1'b1, exp_stall(STD)});
      vecs.push_back('{1'b1, sys2, 1'b0, 1'b0, 1'b0, exp_pass(sys2)});
      // an idle slot clears the pending load
      vecs.push_back('{1'b1, ld3,  1'b0, 1'b0, 1'b0, exp_pass(ld3)});
      vecs.push_back('{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 24'd0});
      vecs.push_back('{1'b1, add3, 1'b0, 1'b0, 1'b0, exp_pass(add3)});

      // reset state, with inputs that would otherwise request a hold
      instr_valid = 1'b1; instr_in = st; mem_busy = 1'b1;
      #1 rst = 1'b0;
      #1;
      check("reset outputs", 32'(out_pk), 32'd0);
      check("reset fetch_hold", 32'(fetch_hold), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i])
         cycle(vecs[i].v, vecs[i].ins, vecs[i].b, vecs[i].f, vecs[i].eh, vecs[i].eo, $sformatf("vec%0d", i));

      // asynchronous reset in the middle of a branch stall
      cycle(1'b1, br,   1'b0, 1'b0, 1'b0, exp_pass(br),   "rst_br issue");
      cycle(1'b1, add2, 1'b0, 1'b0, 1'b1, exp_stall(STD), "rst_br bubble");
      instr_valid = 1'b1; instr_in = st; mem_busy = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("rst_br async outputs", 32'(out_pk), 32'd0);
      check("rst_br async fetch_hold", 32'(fetch_hold), 32'd0);
      instr_in = add2; mem_busy = 1'b0; rst = 1'b1;
      #1;
      check("rst_br release fetch_hold", 32'(fetch_hold), 32'd0);
      @(posedge clk); #1;
      check("rst_br first issue", 32'(out_pk), 32'(exp_pass(add2)));
      @(negedge clk);

      // asynchronous reset in the middle of a load stall drops the dependency
      cycle(1'b1, ld3,  1'b0, 1'b0, 1'b0, exp_pass(ld3),  "rst_ld load");
      cycle(1'b1, add3, 1'b0, 1'b0, 1'b1, exp_stall(STD), "rst_ld bubble");
      #2 rst = 1'b0;
      #1;
      check("rst_ld async outputs", 32'(out_pk), 32'd0);
      rst = 1'b1;
      #1;
      check("rst_ld release fetch_hold", 32'(fetch_hold), 32'd0);
      @(posedge clk); #1;
      check("rst_ld first issue", 32'(out_pk), 32'(exp_pass(add3)));
      @(negedge clk);

      // random traffic against the model; fetch obeys the model's hold
      rst = 1'b0;
      #1 rst = 1'b1;
      m_q.delete(); m_pend = 1'b0; m_lrd = '0;
      prev_hold = 1'b0; cur = '0; cur_v = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (!prev_hold) begin
            cur_v = ($urandom_range(0, 9) != 0);
            cur   = mk(2'($urandom_range(0, 3)), 5'($urandom), 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
         end
         rb = ($urandom_range(0, 3) == 0);
         rf = ($urandom_range(0, 29) == 0);
         model(cur_v, cur, rb, rf, eh, eo);
         cycle(cur_v, cur, rb, rf, eh, eo, "random");
         prev_hold = eh;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
